// File: rtl/pc_gen_if.sv
// Fetch-stage next-PC control bundle: hazard/EX/predecode requests in,
// fetch address and RAS status out.
interface pc_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  stall_i;
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] flush_target_i;
  logic                  trap_i;
  logic [ADDR_WIDTH-1:0] trap_vector_i;
  logic                  call_i;
  logic [ADDR_WIDTH-1:0] call_target_i;
  logic                  ret_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  redirect_o;
  logic                  ras_empty_o;
  logic                  ras_full_o;

  // Requesters (hazard unit, EX, predecoder) drive; fetch address flows back.
  modport master (
    output stall_i, flush_i, flush_target_i, trap_i, trap_vector_i,
           call_i, call_target_i, ret_i,
    input  pc_o, redirect_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, flush_i, flush_target_i, trap_i, trap_vector_i,
           call_i, call_target_i, ret_i,
    output pc_o, redirect_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// Next-PC generator for fetch: prioritised source select (trap > flush >
// stall > ret > call > sequential) with a small circular return-address stack.
// All state updates on the falling clock edge.
module pc_gen #(
  parameter int unsigned                  ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_VECTOR = '0,
  parameter int unsigned                  INC          = 4,
  parameter int unsigned                  RAS_DEPTH    = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  pc_gen_if.slave  bus
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  redirect_q, redirect_d;
  logic [PW-1:0]         tos_q, tos_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_inc;

  // Sequential address wraps modulo 2^ADDR_WIDTH by truncation.
  assign pc_inc = pc_q + ADDR_WIDTH'(INC);

  // Next-PC priority select and RAS push/pop bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    if (bus.trap_i) begin
      pc_d       = bus.trap_vector_i;
      cnt_d      = '0;
      redirect_d = 1'b1;
    end else if (bus.flush_i) begin
      pc_d       = bus.flush_target_i;
      redirect_d = 1'b1;
    end else if (bus.stall_i) begin
      // hold everything; call/ret are ignored while stalled
    end else if (bus.ret_i) begin
      // ret wins over a simultaneous call; empty stack falls back to pc+INC
      if (cnt_q != '0) begin
        pc_d  = ras_q[tos_q];
        tos_d = tos_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        pc_d = pc_inc;
      end
    end else if (bus.call_i) begin
      // when full the push lands on the oldest entry; count saturates
      tos_d        = tos_q + PW'(1);
      ras_d[tos_d] = pc_inc;
      pc_d         = bus.call_target_i;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
    end else begin
      pc_d = pc_inc;
    end
  end

  // Control state: PC, redirect flag, stack pointer and occupancy.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      tos_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stack entries carry no reset; occupancy alone defines validity.
  always_ff @(negedge clk_i) begin
    ras_q <= ras_d;
  end

  assign bus.pc_o        = pc_q;
  assign bus.redirect_o  = redirect_q;
  assign bus.ras_empty_o = (cnt_q == '0);
  assign bus.ras_full_o  = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations are queued when a step is driven
// and popped/compared after the falling edge that should produce them.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst32_n = 1'b0;
  logic rst8_n  = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_WIDTH(32)) b32 ();
  pc_gen_if #(.ADDR_WIDTH(8))  b8 ();

  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4))
    u32 (.clk_i(clk), .rst_ni(rst32_n), .bus(b32));
  pc_gen #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h10), .INC(4), .RAS_DEPTH(4))
    u8 (.clk_i(clk), .rst_ni(rst8_n), .bus(b8));

  typedef struct {
    int          sel;   // 0 = 32-bit DUT, 1 = 8-bit DUT
    string       tag;
    logic [34:0] exp;   // {pc, redirect, empty, full}
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [34:0] obs(input int sel);
    if (sel == 0) return {b32.pc_o, b32.redirect_o, b32.ras_empty_o, b32.ras_full_o};
    return {24'h0, b8.pc_o, b8.redirect_o, b8.ras_empty_o, b8.ras_full_o};
  endfunction

  task automatic push(input int sel, input string tag, input logic [31:0] pc,
                      input logic red, input logic emp, input logic full);
    exp_t e;
    e.sel = sel; e.tag = tag; e.exp = {pc, red, emp, full};
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [34:0] o;
    if (q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e = q.pop_front();
    o = obs(e.sel);
    checks++;
    assert (o === e.exp) else begin
      failures++;
      $error("FAIL %s observed pc=%h red=%b emp=%b full=%b expected pc=%h red=%b emp=%b full=%b",
             e.tag, o[34:3], o[2], o[1], o[0], e.exp[34:3], e.exp[2], e.exp[1], e.exp[0]);
    end
  endtask

  // Check current outputs without a clock edge.
  task automatic now(input int sel, input string tag, input logic [31:0] pc,
                     input logic red, input logic emp, input logic full);
    push(sel, tag, pc, red, emp, full);
    pop_check();
  endtask

  // Inputs already applied; expect result after the next falling edge,
  // then return just after the following rising edge for the next drive.
  task automatic cyc(input int sel, input string tag, input logic [31:0] pc,
                     input logic red, input logic emp, input logic full);
    push(sel, tag, pc, red, emp, full);
    @(negedge clk); #1;
    pop_check();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic st, input logic fl, input logic [31:0] ft,
                     input logic tr, input logic [31:0] tv,
                     input logic ca, input logic [31:0] ct, input logic re);
    b32.stall_i = st; b32.flush_i = fl; b32.flush_target_i = ft;
    b32.trap_i = tr; b32.trap_vector_i = tv;
    b32.call_i = ca; b32.call_target_i = ct; b32.ret_i = re;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    b8.stall_i = 0; b8.flush_i = 0; b8.flush_target_i = 0; b8.trap_i = 0;
    b8.trap_vector_i = 0; b8.call_i = 0; b8.call_target_i = 0; b8.ret_i = 0;

    // Reset and sequential run
    repeat (3) @(posedge clk); #1;
    now(0, "reset", 32'h100, 0, 1, 0);
    rst32_n = 1'b1;
    now(0, "after_release", 32'h100, 0, 1, 0);
    cyc(0, "seq1", 32'h104, 0, 1, 0);
    cyc(0, "seq2", 32'h108, 0, 1, 0);
    cyc(0, "seq3", 32'h10C, 0, 1, 0);

    // Stall vs redirect
    drv(0, 1, 32'h20, 0, 0, 0, 0, 0); cyc(0, "flush_20", 32'h20, 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, "stall1", 32'h20, 0, 1, 0);
    cyc(0, "stall2", 32'h20, 0, 1, 0);
    cyc(0, "stall3", 32'h20, 0, 1, 0);
    drv(1, 1, 32'h80, 0, 0, 0, 0, 0); cyc(0, "stall_flush", 32'h80, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);      cyc(0, "post_flush", 32'h84, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 1, 32'h999, 0); cyc(0, "stall_call", 32'h84, 0, 1, 0);

    // Call/return nesting
    drv(0, 1, 32'h10, 0, 0, 0, 0, 0);  cyc(0, "flush_10", 32'h10, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h200, 0); cyc(0, "call_a", 32'h200, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h300, 0); cyc(0, "call_b", 32'h300, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1);       cyc(0, "ret_b", 32'h204, 0, 0, 0);
    cyc(0, "ret_a", 32'h14, 0, 1, 0);

    // RAS overflow
    drv(0, 0, 0, 1, 32'h0, 0, 0, 0);   cyc(0, "trap_0", 32'h0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h100, 0); cyc(0, "ov_call1", 32'h100, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h200, 0); cyc(0, "ov_call2", 32'h200, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h300, 0); cyc(0, "ov_call3", 32'h300, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h400, 0); cyc(0, "ov_call4", 32'h400, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1, 32'h500, 0); cyc(0, "ov_call5", 32'h500, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, "ov_ret1", 32'h404, 0, 0, 0);
    cyc(0, "ov_ret2", 32'h304, 0, 0, 0);
    cyc(0, "ov_ret3", 32'h204, 0, 0, 0);
    cyc(0, "ov_ret4", 32'h104, 0, 1, 0);
    cyc(0, "ov_ret5_empty", 32'h108, 0, 1, 0);

    // Trap clears RAS, beats a simultaneous flush
    drv(0, 0, 0, 0, 0, 1, 32'h600, 0); cyc(0, "tc_call1", 32'h600, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h700, 0); cyc(0, "tc_call2", 32'h700, 0, 0, 0);
    drv(0, 1, 32'h9000, 1, 32'h8000, 0, 0, 0); cyc(0, "trap_flush", 32'h8000, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1);       cyc(0, "ret_after_trap", 32'h8004, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 32'hA00, 1); cyc(0, "call_and_ret", 32'h8008, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // 8-bit wrap and asynchronous reset
    rst8_n = 1'b1;
    now(1, "rst8_release", 32'h10, 0, 1, 0);
    b8.flush_i = 1; b8.flush_target_i = 8'hFC; cyc(1, "flush_fc", 32'hFC, 1, 1, 0);
    b8.flush_i = 0;                            cyc(1, "wrap", 32'h00, 0, 1, 0);
    b8.flush_i = 1; b8.flush_target_i = 8'h40; cyc(1, "flush_40", 32'h40, 1, 1, 0);
    b8.flush_i = 0;
    rst8_n = 1'b0; #1;
    now(1, "async_reset", 32'h10, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
